// File: rtl/w_row_packer_if.sv
// rtl/w_row_packer_if.sv - beat stream in / packed row out handshake bundle for w_row_packer.
interface w_row_packer_if #(
   parameter int WIDTH = 16,
   parameter int COL   = 64,
   parameter int LANES = 4
);
   logic                    s_valid;
   logic [WIDTH*LANES-1:0]  s_data;
   logic                    s_last;
   logic                    s_ready;
   logic [WIDTH*COL-1:0]    out_row;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output s_valid, s_data, s_last, out_ready,
      input  s_ready, out_row, out_valid
   );

   modport slave (
      input  s_valid, s_data, s_last, out_ready,
      output s_ready, out_row, out_valid
   );
endinterface

// File: rtl/w_row_packer.sv
// rtl/w_row_packer.sv - packs LANES-wide beats into COL-wide weight rows, ROW rows per matrix.
// Optional s_last checking enabled by defining W_ROW_PACKER_ERR_EN.
module w_row_packer #(
   parameter int WIDTH = 16,
   parameter int COL   = 64,
   parameter int ROW   = 256,
   parameter int LANES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            done,
   output logic            err,
   w_row_packer_if.slave   bus
);
   localparam int BPR    = COL / LANES;
   localparam int BW     = (BPR > 1) ? $clog2(BPR) : 1;
   localparam int RW     = $clog2(ROW + 1);
   localparam int BEAT_W = WIDTH * LANES;
   localparam int ROW_W  = WIDTH * COL;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BPR - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROW - 1);

   typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [BW-1:0]     beat_cnt;
   logic [RW-1:0]     rows_in;
   logic [RW-1:0]     rows_out;
   logic [ROW_W-1:0]  asm_q;
   logic [ROW_W-1:0]  asm_nxt;
   logic [ROW_W-1:0]  row_q;
   logic              row_vld;
   logic              ready;
   logic              last_beat;
   logic              accept;
   logic              load;
   logic              xfer;
   logic              enter_pack;

   assign last_beat = (beat_cnt == LAST_BEAT);
   // The final beat must be held off only when the output slot is occupied and not draining.
   assign ready     = (state == PACK) && !(last_beat && row_vld && !bus.out_ready);
   assign accept    = bus.s_valid && ready;
   assign load      = accept && last_beat;
   assign xfer      = row_vld && bus.out_ready;

   assign bus.s_ready   = ready;
   assign bus.out_row   = row_q;
   assign bus.out_valid = row_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      done       = 1'b0;
      enter_pack = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt  = PACK;
               enter_pack = 1'b1;
            end
         end
         PACK: begin
            if (load && rows_in == LAST_ROW) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (xfer && rows_out == LAST_ROW) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt  = PACK;
               enter_pack = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Lanes are MSB-first and columns are MSB-first, so a beat lands as one contiguous slice.
   always_comb begin
      asm_nxt = asm_q;
      for (int b = 0; b < BPR; b++) begin
         if (beat_cnt == BW'(b)) begin
            asm_nxt[ROW_W-1-b*BEAT_W -: BEAT_W] = bus.s_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         rows_in  <= '0;
         rows_out <= '0;
         asm_q    <= '0;
         row_q    <= '0;
         row_vld  <= 1'b0;
      end else if (enter_pack) begin
         beat_cnt <= '0;
         rows_in  <= '0;
         rows_out <= '0;
      end else begin
         if (accept) begin
            asm_q    <= asm_nxt;
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
         end
         if (load) begin
            row_q   <= asm_nxt;
            rows_in <= rows_in + 1'b1;
         end
         if (load) begin
            row_vld <= 1'b1;
         end else if (xfer) begin
            row_vld <= 1'b0;
         end
         if (xfer) begin
            rows_out <= rows_out + 1'b1;
         end
      end
   end

`ifdef W_ROW_PACKER_ERR_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst || enter_pack) begin
         err_q <= 1'b0;
      end else if (accept && (bus.s_last != last_beat)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_s_last;

   assign unused_s_last = bus.s_last;
   assign err           = 1'b0;
`endif
endmodule

// File: doc/w_row_packer.md
W_ROW_PACKER -- requirements
Module: w_row_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bits per element.
REQ-002 SHALL have parameter COL, default 64: elements per weight row; must be a multiple of LANES.
REQ-003 SHALL have parameter ROW, default 256: rows per weight matrix.
REQ-004 SHALL have parameter LANES, default 4: elements per input beat; BPR = COL/LANES beats per row.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle pulse; begins a matrix from IDLE or DONE.
REQ-009 s_valid  in  1  input beat valid.
REQ-010 s_data  in  WIDTH*LANES  lane k at bits [WIDTH*LANES-1-k*WIDTH -: WIDTH].
REQ-011 s_last  in  1  marks the final beat of a row.
REQ-012 s_ready  out  1  beat accepted when s_valid&&s_ready.
REQ-013 out_row  out  WIDTH*COL  packed row; column c at bits [WIDTH*COL-1-c*WIDTH -: WIDTH].
REQ-014 out_valid  out  1  out_row holds an untransferred row.
REQ-015 out_ready  in  1  downstream buffer accepts; transfer on out_valid&&out_ready.
REQ-016 done  out  1  high in DONE.
REQ-017 err  out  1  sticky s_last protocol error.

Function
REQ-018 States: IDLE, PACK, DRAIN, DONE; IDLE->PACK on start; PACK->DRAIN when ROW-th row enters the output register; DRAIN->DONE on ROW-th output transfer; DONE->PACK on start; start ignored in PACK/DRAIN.
REQ-019 Entering PACK SHALL clear beat_cnt, rows_in, rows_out and err.
REQ-020 Accepted beat at beat_cnt=b SHALL write lane k into column b*LANES+k of the assembly register; beat_cnt wraps BPR-1->0.
REQ-021 s_ready = (state==PACK) && !(beat_cnt==BPR-1 && out_valid && !out_ready); combinational from out_ready.
REQ-022 Accepting beat BPR-1 SHALL load the completed row (including that beat) into out_row and set out_valid at the same edge; rows_in increments.
REQ-023 Output transfer and new-row load in the same cycle SHALL keep out_valid high with the new row; transfer alone clears out_valid.
REQ-024 Throughput: one row per BPR cycles with s_valid and out_ready held high; zero bubbles between rows.
REQ-025 out_row SHALL remain stable while out_valid && !out_ready.
REQ-026 rows_out increments per output transfer; no transfer counted when out_valid low.
REQ-027 out_row bits not written in the current row retain prior contents; verification compares complete rows only.

Reset
REQ-028 rst SHALL force state IDLE, beat_cnt=0, rows_in=0, rows_out=0, out_valid=0, out_row=0, err=0, s_ready=0, done=0, within one edge, including mid-row and mid-stall; partial rows are discarded.
REQ-029 rst SHALL take priority over start, s_valid and out_ready in the same cycle.

Configuration
REQ-030 Macro W_ROW_PACKER_ERR_EN defined: err SHALL set when an accepted beat has s_last != (beat_cnt==BPR-1); packing is unaffected; cleared only by rst or entering PACK.
REQ-031 Macro undefined: s_last SHALL be ignored and err tied to 0.

Verification (bench params WIDTH=16, COL=8, LANES=4, ROW=4, BPR=2)
REQ-032 rst, start, beats 0x0001_0002_0003_0004 then 0x0005_0006_0007_0008, out_ready=1 -> out_valid one cycle after 2nd beat, out_row=0x0001..0x0008 MSB-first.
REQ-033 Stream 8 beats continuously, out_ready=1 -> 4 rows, out_valid every 2nd cycle, DONE one cycle after 4th transfer, done=1.
REQ-034 Hold out_ready=0 after row 0 -> beat 0 of row 1 accepted, s_ready=0 at beat 1, out_row stable; raise out_ready -> row 0 and row 1 transfer back-to-back.
REQ-035 Assert rst after one beat of row 2 -> next cycle state IDLE, out_valid=0, done=0; new start packs from column 0.
REQ-036 With W_ROW_PACKER_ERR_EN, s_last=1 on beat 0 -> err=1 next cycle, row still packed correctly; without macro -> err stays 0.
REQ-037 In DONE, s_valid=1 -> s_ready=0; start -> PACK, counters 0, new matrix accepted.
